// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared func codes, ALU signal codes, FSM state type and shift helper
package alu_ctrl_pkg;

  // instruction func field codes
  localparam int F_ADD   = 1;
  localparam int F_AND   = 2;
  localparam int F_COMPL = 3;
  localparam int F_XOR   = 4;
  localparam int F_SLL   = 5;
  localparam int F_SRL   = 6;
  localparam int F_SRA   = 7;
  localparam int F_DIFF  = 8;

  // ALU operation codes driven on alu_signal
  localparam int SIG_NONE  = 0;
  localparam int SIG_ADD   = 1;
  localparam int SIG_AND   = 2;
  localparam int SIG_COMPL = 3;
  localparam int SIG_XOR   = 4;
  localparam int SIG_SLL   = 5;
  localparam int SIG_SRL   = 6;
  localparam int SIG_SRA   = 7;
  localparam int SIG_DIFF  = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BEAT = 1'b1
  } state_t;

  // true for the three func codes that expand into 1-bit shift beats
  function automatic logic is_shift(input int code);
    return (code == F_SLL) || (code == F_SRL) || (code == F_SRA);
  endfunction

endpackage

// File: rtl/alu_func_decode.sv
// rtl/alu_func_decode.sv - combinational func/alu_op to ALU signal decoder
module alu_func_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNC_W = 5,
  parameter int SIG_W  = 4
) (
  input  logic [FUNC_W-1:0] func,
  input  logic              alu_op,
  output logic [SIG_W-1:0]  alu_signal,
  output logic              shift_op,
  output logic              illegal
);

  // alu_op=0 forces add; otherwise map func codes, flag anything unknown
  always_comb begin
    alu_signal = SIG_W'(SIG_NONE);
    shift_op   = 1'b0;
    illegal    = 1'b0;
    if (!alu_op) begin
      alu_signal = SIG_W'(SIG_ADD);
    end else begin
      shift_op = is_shift(int'(func));
      case (int'(func))
        F_ADD:   alu_signal = SIG_W'(SIG_ADD);
        F_AND:   alu_signal = SIG_W'(SIG_AND);
        F_COMPL: alu_signal = SIG_W'(SIG_COMPL);
        F_XOR:   alu_signal = SIG_W'(SIG_XOR);
        F_SLL:   alu_signal = SIG_W'(SIG_SLL);
        F_SRL:   alu_signal = SIG_W'(SIG_SRL);
        F_SRA:   alu_signal = SIG_W'(SIG_SRA);
        F_DIFF:  alu_signal = SIG_W'(SIG_DIFF);
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU control sequencer; ALU_ILLEGAL_TRAP_EN drops illegal funcs and raises illegal_err
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNC_W  = 5,
  parameter int SIG_W   = 4,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNC_W-1:0]  func,
  input  logic               alu_op,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SIG_W-1:0]   alu_signal,
  output logic               shift_en,
  output logic               last,
  output logic               illegal_err
);

  localparam logic [0:0] S_IDLE = ST_IDLE;
  localparam logic [0:0] S_BEAT = ST_BEAT;

  logic [0:0]         state;
  logic [SHAMT_W-1:0] count;   // beats still to follow the one on the outputs
  logic [SIG_W-1:0]   dec_sig;
  logic               dec_shift;
  logic               dec_illegal;
  logic               accept;
  logic               drop;
  logic               multi;

  alu_func_decode #(
    .FUNC_W (FUNC_W),
    .SIG_W  (SIG_W)
  ) u_decode (
    .func       (func),
    .alu_op     (alu_op),
    .alu_signal (dec_sig),
    .shift_op   (dec_shift),
    .illegal    (dec_illegal)
  );

  assign out_valid = (state == S_BEAT);
  // a new request may land on the same edge the final beat is consumed
  assign in_ready  = rst_n && ((state == S_IDLE) || (out_ready && last));
  assign accept    = in_valid && in_ready;
  assign multi     = dec_shift && (shamt != '0);

`ifdef ALU_ILLEGAL_TRAP_EN
  assign drop = dec_illegal;

  // sticky illegal flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_err <= 1'b0;
    end else if (accept && dec_illegal) begin
      illegal_err <= 1'b1;
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
  assign drop           = 1'b0;
  assign illegal_err    = 1'b0;
`endif

  // beat sequencing: load on accept, step the shift counter as beats are consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      alu_signal <= '0;
      shift_en   <= 1'b0;
      last       <= 1'b0;
      count      <= '0;
    end else if (accept && !drop) begin
      state      <= S_BEAT;
      alu_signal <= dec_sig;
      shift_en   <= multi;
      last       <= !multi || (shamt == SHAMT_W'(1));
      count      <= multi ? (shamt - SHAMT_W'(1)) : '0;
    end else if ((state == S_BEAT) && out_ready) begin
      if (last) begin
        state    <= S_IDLE;
        shift_en <= 1'b0;
        last     <= 1'b0;
        count    <= '0;
      end else begin
        count <= count - SHAMT_W'(1);
        last  <= (count == SHAMT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - self-checking bench for alu_ctrl_seq against a beat-list reference model
module tb_alu_ctrl_seq;

  typedef struct {
    logic [4:0] f;
    logic       op;
    logic [4:0] sa;
  } req_t;

  typedef struct {
    logic [3:0] sig;
    logic       sh;
    logic       lst;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] func;
  logic       alu_op;
  logic [4:0] shamt;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_signal;
  logic       shift_en;
  logic       last;
  logic       illegal_err;

  req_t  req_q[$];
  beat_t exp_q[$];
  logic  exp_err;
  bit    held;
  int    total;
  int    passed;

  alu_ctrl_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .func        (func),
    .alu_op      (alu_op),
    .shamt       (shamt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_signal  (alu_signal),
    .shift_en    (shift_en),
    .last        (last),
    .illegal_err (illegal_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // expand one accepted request into the beats the ALU should see
  task automatic model_accept(input req_t r);
    int  code;
    bit  ill;
    ill = 0;
    if (!r.op) code = 1;
    else if (r.f >= 1 && r.f <= 8) code = int'(r.f);
    else begin
      code = 0;
      ill  = 1;
    end
`ifdef ALU_ILLEGAL_TRAP_EN
    if (ill) begin
      exp_err = 1'b1;
      return;
    end
`endif
    if (r.op && r.f >= 5 && r.f <= 7 && r.sa > 0) begin
      for (int i = 1; i <= int'(r.sa); i++)
        exp_q.push_back('{sig: 4'(code), sh: 1'b1, lst: (i == int'(r.sa))});
    end else begin
      exp_q.push_back('{sig: 4'(code), sh: 1'b0, lst: 1'b1});
    end
  endtask

  task automatic push_req(input int f, input int op, input int sa);
    req_q.push_back('{f: 5'(f), op: 1'(op), sa: 5'(sa)});
  endtask

  // one clock: drive at posedge+1, check at negedge, advance the model
  task automatic step(input bit rdy, input bit offer);
    bit iv;
    bit ir_exp;
    iv = (offer || held) && (req_q.size() > 0);
    in_valid = iv;
    if (iv) begin
      func   = req_q[0].f;
      alu_op = req_q[0].op;
      shamt  = req_q[0].sa;
    end else begin
      func   = 5'($urandom);
      alu_op = 1'($urandom);
      shamt  = 5'($urandom);
    end
    out_ready = rdy;
    @(negedge clk);
    ir_exp = (exp_q.size() == 0) || (rdy && exp_q.size() == 1);
    chk("in_ready", 32'(in_ready), 32'(ir_exp));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    chk("illegal_err", 32'(illegal_err), 32'(exp_err));
    if (exp_q.size() > 0) begin
      chk("alu_signal", 32'(alu_signal), 32'(exp_q[0].sig));
      chk("shift_en", 32'(shift_en), 32'(exp_q[0].sh));
      chk("last", 32'(last), 32'(exp_q[0].lst));
      if (rdy) void'(exp_q.pop_front());
    end
    held = iv && !ir_exp;
    if (iv && ir_exp) model_accept(req_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((req_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step(1'b1, 1'b1);
      n++;
    end
    if (req_q.size() > 0 || exp_q.size() > 0) chk("drain_timeout", 32'd1, 32'd0);
    step(1'b1, 1'b0);
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    exp_err   = 1'b0;
    held      = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    func      = '0;
    alu_op    = 1'b0;
    shamt     = '0;
    out_ready = 1'b0;

    // reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_signal", 32'(alu_signal), 32'd0);
    chk("rst_shift_en", 32'(shift_en), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_illegal_err", 32'(illegal_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0);

    // alu_op=0 forces add
    push_req(7, 0, 0);
    drain(10);

    // back-to-back and, xor, diff
    push_req(2, 1, 0);
    push_req(4, 1, 0);
    push_req(8, 1, 0);
    drain(10);

    // sra shamt=3 with a stall cycle
    push_req(7, 1, 3);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // srl shamt=0 pass-through, then longest shift
    push_req(6, 1, 0);
    push_req(5, 1, 31);
    drain(60);

    // illegal func
    push_req(15, 1, 0);
    push_req(2, 1, 0);
    drain(10);

    // reset in the middle of sll shamt=5
    push_req(5, 1, 5);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_alu_signal", 32'(alu_signal), 32'd0);
    chk("midrst_shift_en", 32'(shift_en), 32'd0);
    chk("midrst_last", 32'(last), 32'd0);
    chk("midrst_illegal_err", 32'(illegal_err), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    req_q.delete();
    exp_err = 1'b0;
    held    = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step(1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int sa;
      sa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
      push_req(int'($urandom_range(0, 31)) % (($urandom_range(0, 3) == 0) ? 32 : 9),
               int'($urandom_range(0, 5) != 0), sa);
    end
    for (int c = 0; c < 6000 && (req_q.size() > 0 || exp_q.size() > 0); c++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    drain(100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
